// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader and the memory subsystem:
// bit timing, loader state encodings and word geometry.
package uart_loader_pkg;

  localparam int unsigned DEF_SYS_CLK_FREQ   = 32'd100000000;
  localparam int unsigned DEF_UART_BAUD_RATE = 32'd115200;
  localparam int unsigned BYTES_PER_WORD     = 32'd4;

  function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

  // 868 system clocks per serial bit at the default rates
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(DEF_SYS_CLK_FREQ, DEF_UART_BAUD_RATE);

  typedef enum logic [2:0] {
    LD_LEN   = 3'd0,
    LD_WORD  = 3'd1,
    LD_WRITE = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERROR = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 serial receiver: synchronizes rx, samples mid-bit and emits one-cycle
// byte_valid pulses, or a stop_error pulse when the stop bit reads 0.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 32'd868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_error
);

  localparam int unsigned          CNT_W    = $clog2(BIT_TICKS + 32'd1);
  localparam logic [CNT_W-1:0]     FULL_END = CNT_W'(BIT_TICKS - 32'd1);
  localparam logic [CNT_W-1:0]     HALF_END = CNT_W'(BIT_TICKS / 32'd2 - 32'd1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(32'd1);

  logic             sync1_r, sync2_r;
  rx_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       bit_r, bit_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic [7:0]       data_r, data_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             err_r, err_nxt_s;

  // two-flop synchronizer, preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  // receive FSM next-state, bit timing and output decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_nxt_s = '0;
        if (!sync2_r) state_nxt_s = RX_START;
        else          state_nxt_s = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_END) begin
          cnt_nxt_s = '0;
          bit_nxt_s = 3'd0;
          // a line already back high at mid start bit was only a glitch
          if (sync2_r) state_nxt_s = RX_IDLE;
          else         state_nxt_s = RX_DATA;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_r == FULL_END) begin
          cnt_nxt_s   = '0;
          shift_nxt_s = {sync2_r, shift_r[7:1]};
          if (bit_r == 3'd7) state_nxt_s = RX_STOP;
          else               bit_nxt_s   = bit_r + 3'd1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_END) begin
          cnt_nxt_s   = '0;
          state_nxt_s = RX_IDLE;
          if (sync2_r) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = shift_r;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: state_nxt_s = RX_IDLE;
    endcase
  end

  // receive state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= RX_IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign byte_valid = valid_r;
  assign byte_data  = data_r;
  assign stop_error = err_r;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a little-endian word count followed by that many
// words over UART and writes them to consecutive memory words from address 0.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 32'd100000000,
  parameter int unsigned UART_BAUD_RATE = 32'd115200,
  parameter int unsigned ADDR_WIDTH     = 32'd17,
  parameter int unsigned LEN            = 32'd32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  mem_write_ready,
  output logic                  load_write_en,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic [LEN-1:0]        load_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  frame_error
);

  localparam int unsigned BIT_CLKS  = clks_per_bit(SYS_CLK_FREQ, UART_BAUD_RATE);
  localparam int unsigned IDX_W     = ADDR_WIDTH - 32'd1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << (ADDR_WIDTH - 32'd2);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 32'd1);

  logic                  rx_valid_s, rx_err_s;
  logic [7:0]            rx_byte_s;
  loader_state_t         state_r, state_nxt_s;
  logic [1:0]            byte_cnt_r, byte_cnt_nxt_s;
  logic [LEN-1:0]        asm_r, asm_nxt_s, asm_shift_s;
  logic [31:0]           count_r, count_nxt_s, count_new_s, idx_inc_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic [LEN-1:0]        data_r, data_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  write_en_r, hold_r, done_r, ferr_r;

  uart_rx #(.BIT_TICKS(BIT_CLKS)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (rx_valid_s),
    .byte_data  (rx_byte_s),
    .stop_error (rx_err_s)
  );

  // bytes arrive LSB-first, so each new byte enters at the top
  assign asm_shift_s = {rx_byte_s, asm_r[LEN-1:8]};
  assign count_new_s = asm_shift_s[31:0];
  assign idx_inc_s   = 32'(idx_r) + 32'd1;

  // loader FSM next-state and datapath updates
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    asm_nxt_s      = asm_r;
    count_nxt_s    = count_r;
    idx_nxt_s      = idx_r;
    data_nxt_s     = data_r;
    case (state_r)
      LD_LEN: begin
        if (rx_err_s) begin
          state_nxt_s = LD_ERROR;
        end else if (rx_valid_s) begin
          asm_nxt_s      = asm_shift_s;
          byte_cnt_nxt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == LAST_BYTE) begin
            count_nxt_s = count_new_s;
            if (count_new_s == 32'd0)          state_nxt_s = LD_DONE;
            else if (count_new_s > MAX_WORDS)  state_nxt_s = LD_ERROR;
            else                               state_nxt_s = LD_WORD;
          end else begin
            state_nxt_s = LD_LEN;
          end
        end else begin
          state_nxt_s = LD_LEN;
        end
      end
      LD_WORD: begin
        if (rx_err_s) begin
          state_nxt_s = LD_ERROR;
        end else if (rx_valid_s) begin
          asm_nxt_s      = asm_shift_s;
          byte_cnt_nxt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == LAST_BYTE) begin
            data_nxt_s  = asm_shift_s;
            state_nxt_s = LD_WRITE;
          end else begin
            state_nxt_s = LD_WORD;
          end
        end else begin
          state_nxt_s = LD_WORD;
        end
      end
      LD_WRITE: begin
        // a byte landing before the pending word is accepted is an overrun
        if (rx_err_s || rx_valid_s) begin
          state_nxt_s = LD_ERROR;
        end else if (mem_write_ready) begin
          idx_nxt_s = IDX_W'(idx_inc_s);
          if (idx_inc_s == count_r) state_nxt_s = LD_DONE;
          else                      state_nxt_s = LD_WORD;
        end else begin
          state_nxt_s = LD_WRITE;
        end
      end
      LD_DONE:  state_nxt_s = LD_DONE;
      LD_ERROR: state_nxt_s = LD_ERROR;
      default:  state_nxt_s = LD_ERROR;
    endcase
  end

  // loader state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= LD_LEN;
      byte_cnt_r <= 2'd0;
      asm_r      <= '0;
      count_r    <= 32'd0;
      idx_r      <= '0;
      data_r     <= '0;
      addr_r     <= '0;
      write_en_r <= 1'b0;
      hold_r     <= 1'b1;
      done_r     <= 1'b0;
      ferr_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      asm_r      <= asm_nxt_s;
      count_r    <= count_nxt_s;
      idx_r      <= idx_nxt_s;
      data_r     <= data_nxt_s;
      write_en_r <= (state_nxt_s == LD_WRITE);
      // address only moves when a write is posted, so it never passes the last word
      if (state_nxt_s == LD_WRITE) addr_r <= {idx_r[ADDR_WIDTH-3:0], 2'b00};
      else                         addr_r <= addr_r;
      done_r     <= done_r | (state_r == LD_DONE);
      hold_r     <= ~(done_r | (state_r == LD_DONE));
      ferr_r     <= ferr_r | (state_nxt_s == LD_ERROR);
    end
  end

  assign load_write_en = write_en_r;
  assign load_addr     = addr_r;
  assign load_data     = data_r;
  assign core_hold     = hold_r;
  assign load_done     = done_r;
  assign frame_error   = ferr_r;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: a fast-baud instance for the loader protocol
// and a default-rate instance for the start-bit glitch filter.
module tb_uart_loader;

  localparam int FAST_CPB = 16;
  localparam int SLOW_CPB = 868;

  logic        clk = 1'b0;
  logic        rst, rx_m, rx_g, ready_m, ready_g;
  logic        we_m, hold_m, done_m, ferr_m;
  logic [16:0] addr_m;
  logic [31:0] data_m;
  logic        we_g, hold_g, done_g, ferr_g;
  logic [16:0] addr_g;
  logic [31:0] data_g;

  int errors = 0;
  int checks = 0;
  int bv_g   = 0;
  logic [16:0] addr_q[$];
  logic [31:0] data_q[$];

  uart_loader #(.SYS_CLK_FREQ(1600000), .UART_BAUD_RATE(100000),
                .ADDR_WIDTH(17), .LEN(32)) dut (
    .clk(clk), .rst(rst), .rx(rx_m), .mem_write_ready(ready_m),
    .load_write_en(we_m), .load_addr(addr_m), .load_data(data_m),
    .core_hold(hold_m), .load_done(done_m), .frame_error(ferr_m));

  uart_loader dut_g (
    .clk(clk), .rst(rst), .rx(rx_g), .mem_write_ready(ready_g),
    .load_write_en(we_g), .load_addr(addr_g), .load_data(data_g),
    .core_hold(hold_g), .load_done(done_g), .frame_error(ferr_g));

  always #5 clk = ~clk;

  // accepted writes on the fast instance
  always @(negedge clk) begin
    if (rst && we_m && ready_m) begin
      addr_q.push_back(addr_m);
      data_q.push_back(data_m);
    end
  end

  // received bytes on the default-rate instance
  always @(negedge clk) begin
    if (rst && dut_g.u_rx.byte_valid) bv_g++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input bit slow, input logic v);
    if (slow) rx_g = v;
    else      rx_m = v;
  endtask

  task automatic send_byte(input bit slow, input logic [7:0] b, input logic stop_bit);
    int cpb;
    logic [9:0] frame;
    cpb   = slow ? SLOW_CPB : FAST_CPB;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(slow, frame[i]);
      tick(cpb);
    end
    set_rx(slow, 1'b1);
  endtask

  task automatic send_word(input bit slow, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(slow, w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    int base;
    int waited;
    int held;
    bit stable;

    rst = 1'b0; rx_m = 1'b1; rx_g = 1'b1; ready_m = 1'b1; ready_g = 1'b1;
    tick(3);
    check_val("rst_we",   we_m,   64'd0);
    check_val("rst_addr", addr_m, 64'd0);
    check_val("rst_data", data_m, 64'd0);
    check_val("rst_hold", hold_m, 64'd1);
    check_val("rst_done", done_m, 64'd0);
    check_val("rst_ferr", ferr_m, 64'd0);
    rst = 1'b1;
    tick(2);

    // two words, memory always ready
    base = addr_q.size();
    send_word(1'b0, 32'd2);
    send_word(1'b0, 32'h0000_0013);
    send_word(1'b0, 32'hDEAD_BEEF);
    tick(5);
    check_val("t1_nwr", addr_q.size() - base, 64'd2);
    if (addr_q.size() >= base + 2) begin
      check_val("t1_a0", addr_q[base],     64'h00000);
      check_val("t1_d0", data_q[base],     64'h00000013);
      check_val("t1_a1", addr_q[base + 1], 64'h00004);
      check_val("t1_d1", data_q[base + 1], 64'hDEADBEEF);
    end
    check_val("t1_done", done_m, 64'd1);
    check_val("t1_hold", hold_m, 64'd0);
    check_val("t1_ferr", ferr_m, 64'd0);

    // one word with memory stalled for 50 cycles
    do_reset();
    base = addr_q.size();
    ready_m = 1'b0;
    send_word(1'b0, 32'd1);
    send_word(1'b0, 32'h1234_5678);
    waited = 0;
    while (!we_m && waited < 100) begin
      tick(1);
      waited++;
    end
    check_val("t2_we_seen", we_m, 64'd1);
    held = 0;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (we_m) held++;
      if (addr_m !== 17'd0 || data_m !== 32'h1234_5678) stable = 1'b0;
      tick(1);
    end
    check_val("t2_held",   held,   64'd50);
    check_val("t2_stable", stable, 64'd1);
    ready_m = 1'b1;
    tick(4);
    check_val("t2_nwr", addr_q.size() - base, 64'd1);
    if (addr_q.size() >= base + 1) begin
      check_val("t2_a0", addr_q[base], 64'h00000);
      check_val("t2_d0", data_q[base], 64'h12345678);
    end
    check_val("t2_we_off", we_m,   64'd0);
    check_val("t2_done",   done_m, 64'd1);

    // bad stop bit in the middle of a word
    do_reset();
    base = addr_q.size();
    send_word(1'b0, 32'd1);
    send_byte(1'b0, 8'hAA, 1'b1);
    send_byte(1'b0, 8'h55, 1'b0);
    tick(5);
    check_val("t3_ferr", ferr_m, 64'd1);
    check_val("t3_nwr",  addr_q.size() - base, 64'd0);
    check_val("t3_hold", hold_m, 64'd1);
    check_val("t3_done", done_m, 64'd0);

    // empty program
    do_reset();
    base = addr_q.size();
    send_word(1'b0, 32'd0);
    tick(5);
    check_val("t4_done", done_m, 64'd1);
    check_val("t4_hold", hold_m, 64'd0);
    check_val("t4_nwr",  addr_q.size() - base, 64'd0);
    check_val("t4_ferr", ferr_m, 64'd0);

    // one word more than the address space holds
    do_reset();
    send_word(1'b0, 32'h0000_8001);
    tick(5);
    check_val("t4b_ferr", ferr_m, 64'd1);
    check_val("t4b_done", done_m, 64'd0);
    check_val("t4b_hold", hold_m, 64'd1);
    check_val("t4b_we",   we_m,   64'd0);

    // reset in the middle of the second word, then a fresh frame
    do_reset();
    base = addr_q.size();
    send_word(1'b0, 32'd2);
    send_word(1'b0, 32'h1111_1111);
    send_byte(1'b0, 8'h22, 1'b1);
    send_byte(1'b0, 8'h33, 1'b1);
    check_val("t5_pre_nwr", addr_q.size() - base, 64'd1);
    rx_m = 1'b0;
    tick(20);
    rst = 1'b0;
    tick(2);
    rx_m = 1'b1;
    tick(1);
    check_val("t5_rst_we",   we_m,   64'd0);
    check_val("t5_rst_data", data_m, 64'd0);
    check_val("t5_rst_hold", hold_m, 64'd1);
    rst = 1'b1;
    tick(40);
    base = addr_q.size();
    send_word(1'b0, 32'd1);
    send_word(1'b0, 32'hCAFE_F00D);
    tick(5);
    check_val("t5_nwr", addr_q.size() - base, 64'd1);
    if (addr_q.size() >= base + 1) begin
      check_val("t5_a0", addr_q[base], 64'h00000);
      check_val("t5_d0", data_q[base], 64'hCAFEF00D);
    end
    check_val("t5_done", done_m, 64'd1);
    check_val("t5_ferr", ferr_m, 64'd0);

    // 300-cycle low pulse at the default bit rate is shorter than half a bit
    rx_g = 1'b0;
    tick(300);
    rx_g = 1'b1;
    tick(1000);
    check_val("g_bv_glitch", bv_g,   64'd0);
    check_val("g_done_pre",  done_g, 64'd0);
    check_val("g_ferr_pre",  ferr_g, 64'd0);
    send_word(1'b1, 32'd0);
    tick(5);
    check_val("g_bv_frame", bv_g,   64'd4);
    check_val("g_done",     done_g, 64'd1);
    check_val("g_hold",     hold_g, 64'd0);
    check_val("g_ferr",     ferr_g, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter ADDR_WIDTH, default 17, main-memory byte-address width.
REQ-004 SHALL have parameter LEN, default 32, word width.
REQ-005 SHALL have one clock and a synchronous, active-low reset; ports follow.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous active-low reset.
REQ-008 rx  input  1  asynchronous UART receive line, idle high.
REQ-009 mem_write_ready  input  1  main memory accepts the presented word this cycle.
REQ-010 load_write_en  output  1  word write request to main memory.
REQ-011 load_addr  output  ADDR_WIDTH  byte address of the word being written.
REQ-012 load_data  output  LEN  word being written, little-endian assembled.
REQ-013 core_hold  output  1  holds CORE in reset until the load completes.
REQ-014 load_done  output  1  sticky; program fully written.
REQ-015 frame_error  output  1  sticky; protocol or UART error detected.

Function
REQ-016 rx SHALL pass a 2-flop synchronizer before any use.
REQ-017 CLKS_PER_BIT SHALL equal SYS_CLK_FREQ/UART_BAUD_RATE (868 at defaults); the bit counter SHALL be sized to hold it.
REQ-018 RX FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START on synced rx falling to 0; START samples at CLKS_PER_BIT/2 and returns to IDLE if rx is 1 (glitch), else -> DATA; DATA samples 8 bits LSB first, one every CLKS_PER_BIT; STOP samples once after CLKS_PER_BIT.
REQ-019 Stop bit 1 SHALL emit a one-cycle byte_valid; stop bit 0 SHALL drop the byte and set frame_error.
REQ-020 Loader FSM SHALL have states LEN, WORD, WRITE, DONE, ERROR.
REQ-021 LEN collects 4 bytes little-endian into word count N; on the 4th byte -> DONE if N==0, -> ERROR if N > 2^(ADDR_WIDTH-2), else -> WORD.
REQ-022 WORD collects 4 bytes little-endian into load_data and -> WRITE on the 4th byte.
REQ-023 In WRITE, load_write_en SHALL be 1 with load_addr = 4*word_index and load_data stable until mem_write_ready is 1 in the same cycle.
REQ-024 On acceptance, word_index SHALL increment and the FSM SHALL -> DONE if word_index+1 == N, else -> WORD.
REQ-025 Any byte_valid arriving while in WRITE (overrun) SHALL set frame_error and -> ERROR.
REQ-026 DONE SHALL set load_done=1 and core_hold=0 one cycle after entry; further RX bytes SHALL be ignored.
REQ-027 ERROR SHALL be terminal until reset: core_hold=1, load_write_en=0, frame_error=1.
REQ-028 frame_error SHALL move the loader FSM to ERROR from any state except DONE.
REQ-029 load_addr SHALL never wrap; REQ-021 bounds N so the last address is 2^ADDR_WIDTH-4.

Reset
REQ-030 With rst=0 at a clock edge, both FSMs SHALL go to IDLE/LEN and outputs SHALL be: load_write_en=0, load_addr=0, load_data=0, core_hold=1, load_done=0, frame_error=0; the synchronizer SHALL preset to 1.
REQ-031 Reset mid-byte or mid-write SHALL discard all partial state; the next frame SHALL start from LEN.

Structure
REQ-032 CLKS_PER_BIT, loader state encodings and the 4-byte-per-word constant SHALL live in the shared package used by the memory subsystem.
REQ-033 The serial receiver SHALL be one sub-module, uart_rx (sync, RX FSM, byte_valid/byte_data out); uart_loader SHALL instantiate it once.

Verification
REQ-034 Send N=2, words 0x00000013, 0xDEADBEEF, mem_write_ready=1 -> writes (0x00000,0x00000013), (0x00004,0xDEADBEEF); load_done=1, core_hold=0.
REQ-035 N=1, word 0x12345678, mem_write_ready low for 50 cycles -> load_write_en held 50 cycles with stable addr/data; exactly one accepted write.
REQ-036 Byte with stop bit 0 during WORD -> frame_error=1, no write issued, core_hold stays 1.
REQ-037 N=0 -> load_done=1 with no writes; N=0x00008001 -> ERROR, frame_error=1.
REQ-038 300-cycle low glitch on rx in IDLE -> no byte_valid; rst=0 mid-second-word then a fresh N=1 frame -> single write at address 0.
